fpu_req_scheduler: RTL

Shares one single-precision FPU datapath (combinational adder and multiplier instances) between two requesters. It arbitrates round-robin, latches the winning operands, and drives them onto the shared adder/multiplier inputs. It waits a programmable settle time, captures the selected result, and returns it with the requester ID over a valid/ready result channel. It sits between client engines and the top-level adder/multiplication instances.

---
 rtl/fpu_req_scheduler.sv | 109 ++++++++++
 1 files changed

// File: rtl/fpu_req_scheduler.sv
// Round-robin scheduler that time-shares one combinational FP adder/multiplier
// pair between two requesters and returns results over a valid/ready channel.
module fpu_req_scheduler #(
  parameter int unsigned FPU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      add_result,
  input  logic [31:0]      mul_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(FPU_LAT);

  state_t     state, state_nxt;
  logic       any_valid;
  logic       grant;
  logic       last_grant;
  logic       op_q;
  logic       id_q;
  logic [3:0] lat_cnt;

  // On a tie the requester that did not win last time gets the slot.
  assign any_valid = req0_valid | req1_valid;
  assign grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid)     state_nxt = EXEC;
      EXEC:    if (lat_cnt == 4'd1) state_nxt = DONE;
      DONE:    if (res_ready)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && req0_valid && !grant;
    req1_ready = (state == IDLE) && req1_valid &&  grant;
    res_valid  = (state == DONE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a      <= '0;
      fpu_b      <= '0;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      lat_cnt    <= '0;
      res_data   <= '0;
      res_id     <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            fpu_a      <= grant ? req1_a  : req0_a;
            fpu_b      <= grant ? req1_b  : req0_b;
            op_q       <= grant ? req1_op : req0_op;
            id_q       <= grant;
            last_grant <= grant;
            lat_cnt    <= LAT_LOAD;
          end
        end
        EXEC: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            res_data <= op_q ? mul_result : add_result;
            res_id   <= id_q;
          end
        end
        DONE: begin
          if (res_ready) ops_done <= ops_done + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
